// File: rtl/instr_issue.sv
// Instruction fetch/issue sequencer: reads opcodes from a synchronous-read
// program memory starting at PC 0 and offers them over a valid/ready handshake.
module instr_issue #(
  parameter int                 ADDR_W  = 8,
  parameter int                 INSTR_W = 4,
  parameter logic [INSTR_W-1:0] HALT_OP = 4'hF
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  output logic               imem_rd,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic [INSTR_W-1:0] imem_data,
  output logic [INSTR_W-1:0] instr,
  output logic               instr_valid,
  input  logic               instr_ready,
  output logic [ADDR_W-1:0]  pc,
  output logic               halted,
  output logic [15:0]        issue_count
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_CAPTURE,
    S_ISSUE,
    S_HALTED
  } state_t;

  state_t state;

  // NOTE: the reset branch sits in the sensitivity list so it acts immediately,
  // and every state element uses <= so all flops update from the same snapshot.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= S_IDLE;
      pc          <= '0;
      instr       <= '0;
      issue_count <= '0;
    end else begin
      case (state)
        S_IDLE, S_HALTED: begin
          if (start) begin
            pc          <= '0;
            issue_count <= '0;
            state       <= S_FETCH;
          end
        end
        S_FETCH: state <= S_CAPTURE;
        S_CAPTURE: begin
          // A HALT opcode is never offered, so instr keeps the last issued value.
          if (imem_data == HALT_OP) begin
            state <= S_HALTED;
          end else begin
            instr <= imem_data;
            state <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          if (instr_ready) begin
            pc <= pc + ADDR_W'(1);
            if (issue_count != 16'hFFFF) issue_count <= issue_count + 16'd1;
            state <= S_FETCH;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Moore outputs decoded from the state register only.
  assign imem_rd     = (state == S_FETCH);
  assign instr_valid = (state == S_ISSUE);
  assign halted      = (state == S_HALTED);
  assign imem_addr   = pc;

endmodule

// File: tb/tb_instr_issue.sv
// Self-checking bench for instr_issue: directed and randomized programs compared
// against a stream-level reference model, plus a small-address wrap instance.
module tb_instr_issue;

  localparam logic [3:0] HALT = 4'hF;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        instr_ready;
  logic        imem_rd;
  logic [7:0]  imem_addr;
  logic [3:0]  imem_data;
  logic [3:0]  instr;
  logic        instr_valid;
  logic [7:0]  pc;
  logic        halted;
  logic [15:0] issue_count;

  logic        start_w;
  logic        imem_rd_w;
  logic [1:0]  imem_addr_w;
  logic [3:0]  imem_data_w;
  logic [3:0]  instr_w;
  logic        instr_valid_w;
  logic [1:0]  pc_w;
  logic        halted_w;
  logic [15:0] issue_count_w;

  logic [3:0] mem [256];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  instr_issue #(.ADDR_W(8), .INSTR_W(4), .HALT_OP(4'hF)) u_dut (
    .clk(clk), .reset(reset), .start(start),
    .imem_rd(imem_rd), .imem_addr(imem_addr), .imem_data(imem_data),
    .instr(instr), .instr_valid(instr_valid), .instr_ready(instr_ready),
    .pc(pc), .halted(halted), .issue_count(issue_count)
  );

  instr_issue #(.ADDR_W(2), .INSTR_W(4), .HALT_OP(4'hF)) u_wrap (
    .clk(clk), .reset(reset), .start(start_w),
    .imem_rd(imem_rd_w), .imem_addr(imem_addr_w), .imem_data(imem_data_w),
    .instr(instr_w), .instr_valid(instr_valid_w), .instr_ready(1'b1),
    .pc(pc_w), .halted(halted_w), .issue_count(issue_count_w)
  );

  // Synchronous-read program memories: data appears the cycle after the strobe.
  always @(posedge clk) if (imem_rd) imem_data <= mem[imem_addr];
  always @(posedge clk) if (imem_rd_w) imem_data_w <= 4'h7;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_rd"},    imem_rd,     0);
    check({tag, "_addr"},  imem_addr,   0);
    check({tag, "_instr"}, instr,       0);
    check({tag, "_valid"}, instr_valid, 0);
    check({tag, "_pc"},    pc,          0);
    check({tag, "_halt"},  halted,      0);
    check({tag, "_cnt"},   issue_count, 0);
  endtask

  // Reference: the issued stream is every opcode from address 0 up to the first
  // HALT; each is offered 3 cycles after the previous accept (or the start).
  task automatic run_prog(input int min_stall, input int max_stall, input bit rand_start);
    logic [3:0] ops[$];
    int p;
    int stall;
    p = 0;
    while (mem[p] != HALT && ops.size() < 40) begin
      ops.push_back(mem[p]);
      p = (p + 1) % 256;
    end
    start = 1'b1;
    instr_ready = 1'b0;
    tick();
    start = 1'b0;
    for (int n = 0; n <= ops.size(); n++) begin
      check("fetch_rd",    imem_rd,     1);
      check("fetch_addr",  imem_addr,   n % 256);
      check("fetch_cnt",   issue_count, n);
      check("fetch_valid", instr_valid, 0);
      instr_ready = 1'($urandom);
      start = rand_start ? 1'($urandom) : 1'b0;
      tick();
      check("capture_rd",    imem_rd,     0);
      check("capture_valid", instr_valid, 0);
      instr_ready = 1'($urandom);
      start = rand_start ? 1'($urandom) : 1'b0;
      tick();
      start = 1'b0;
      instr_ready = 1'b0;
      if (n == ops.size()) begin
        check("halt_flag",  halted,      1);
        check("halt_valid", instr_valid, 0);
        check("halt_pc",    pc,          p);
        check("halt_cnt",   issue_count, n);
        check("halt_rd",    imem_rd,     0);
      end else begin
        stall = $urandom_range(max_stall, min_stall);
        for (int s = 0; s <= stall; s++) begin
          check("issue_valid", instr_valid, 1);
          check("issue_instr", instr,       ops[n]);
          check("issue_pc",    pc,          n);
          check("issue_rd",    imem_rd,     0);
          check("issue_halt",  halted,      0);
          check("issue_cnt",   issue_count, n);
          instr_ready = (s == stall);
          start = rand_start ? 1'($urandom) : 1'b0;
          tick();
        end
        start = 1'b0;
        instr_ready = 1'b0;
      end
    end
  endtask

  initial begin
    reset = 1'b0;
    start = 1'b0;
    start_w = 1'b0;
    instr_ready = 1'b0;
    foreach (mem[i]) mem[i] = 4'h0;
    tick();
    tick();
    check_all_zero("reset");
    check("reset_w_rd", imem_rd_w, 0);
    reset = 1'b1;

    // Idle without start, even with instr_ready asserted.
    instr_ready = 1'b1;
    tick();
    tick();
    check("idle_rd",    imem_rd,     0);
    check("idle_valid", instr_valid, 0);
    instr_ready = 1'b0;

    // Basic sequence, no stalls.
    mem[0] = 4'h1; mem[1] = 4'h2; mem[2] = 4'h3; mem[3] = HALT;
    run_prog(0, 0, 1'b0);

    // Restart after halt replays the program identically.
    run_prog(0, 0, 1'b0);

    // Backpressure: ten cycles without ready before the accept.
    mem[0] = 4'h5; mem[1] = HALT;
    run_prog(10, 10, 1'b0);

    // Immediate halt.
    mem[0] = HALT;
    run_prog(0, 0, 1'b0);

    // Randomized programs with opcode 0 allowed, random stalls, stray start pulses.
    for (int t = 0; t < 6; t++) begin
      int len;
      foreach (mem[i]) mem[i] = 4'($urandom_range(14, 0));
      len = $urandom_range(6, 1);
      mem[len] = HALT;
      if (t == 0) mem[0] = 4'h0;
      run_prog(0, 3, 1'b1);
    end

    // Asynchronous reset while an instruction is being offered.
    mem[0] = 4'h9; mem[1] = 4'h4; mem[2] = HALT;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    instr_ready = 1'b1;
    tick();
    instr_ready = 1'b0;
    tick();
    tick();
    check("pre_rst_valid", instr_valid, 1);
    check("pre_rst_instr", instr,       4);
    check("pre_rst_pc",    pc,          1);
    #2 reset = 1'b0;
    #1 check_all_zero("async_rst");
    @(negedge clk);
    reset = 1'b1;
    instr_ready = 1'b1;
    tick();
    tick();
    check("post_rst_rd",    imem_rd,     0);
    check("post_rst_valid", instr_valid, 0);
    instr_ready = 1'b0;

    // PC wrap on the 2-bit-address instance, ready tied high.
    start_w = 1'b1;
    tick();
    start_w = 1'b0;
    for (int i = 0; i < 6; i++) begin
      check("wrap_rd",   imem_rd_w,     1);
      check("wrap_addr", imem_addr_w,   i % 4);
      check("wrap_cnt",  issue_count_w, i);
      tick();
      tick();
      check("wrap_valid", instr_valid_w, 1);
      check("wrap_instr", instr_w,       7);
      check("wrap_halt",  halted_w,      0);
      tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/instr_issue.md
Name: instr_issue

Overview:
- Instruction fetch/issue sequencer that feeds opcodes to exe_engine's instruction input.
- Reads opcodes from a synchronous-read program memory, starting at a program counter (PC) of 0.
- Presents each opcode to the execution side with a valid/ready handshake.
- Stops on a HALT opcode. It is the producer of the instruction stream that exe_engine decodes into control bits.

Parameters:
- ADDR_W, 8: program memory address width; PC range 0 .. 2^ADDR_W-1.
- INSTR_W, 4: opcode width; matches exe_engine instr input.
- HALT_OP, 4'hF: opcode value that stops fetching. It is never issued.

Ports:
- clk  in  1  system clock; all state changes on rising edge.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  begin fetching from PC=0. Honoured only in IDLE or HALTED.
- imem_rd  out  1  program memory read strobe.
- imem_addr  out  ADDR_W  program memory read address.
- imem_data  in  INSTR_W  program memory read data. Valid the cycle after the cycle in which imem_rd=1.
- instr  out  INSTR_W  opcode presented to exe_engine.
- instr_valid  out  1  instr is valid and being offered.
- instr_ready  in  1  exe_engine accepts instr at this rising edge.
- pc  out  ADDR_W  current program counter.
- halted  out  1  HALT_OP fetched; sequencer stopped.
- issue_count  out  16  number of instructions accepted since the last start. Saturates at 16'hFFFF.

Behaviour:
- Reset (reset=0, asynchronous, effective immediately, including mid-operation):
  - state=IDLE; pc=0; instr=0; instr_valid=0; imem_rd=0; imem_addr=0; halted=0; issue_count=0.
  - Any in-flight fetch or offered instruction is abandoned.
- Outputs:
  - All outputs are registered or decoded from registered state (Moore). No combinational path from instr_ready or imem_data to any output.
  - imem_addr = pc at all times.
  - imem_rd=1 only in FETCH.
  - instr_valid=1 only in ISSUE.
  - halted=1 only in HALTED.
- IDLE: wait. If start=1 at an edge: pc<=0, issue_count<=0, go to FETCH.
- FETCH (1 cycle): imem_rd=1, imem_addr=pc. Go to CAPTURE.
- CAPTURE (1 cycle): imem_data is valid this cycle.
  - If imem_data==HALT_OP: go to HALTED; instr is unchanged.
  - Else: instr<=imem_data, go to ISSUE.
- ISSUE: instr_valid=1; instr is held stable until accepted.
  - If instr_ready=1 at an edge: handshake completes; pc<=pc+1; issue_count<=issue_count+1 (saturating); go to FETCH.
  - If instr_ready=0: remain in ISSUE indefinitely. instr and pc do not change.
- HALTED: pc holds the address of the HALT opcode. start=1 at an edge: halted<=0, pc<=0, issue_count<=0, go to FETCH.
- start is ignored in FETCH, CAPTURE and ISSUE.
- Latency:
  - start sampled at edge E → imem_rd=1 in the cycle after E.
  - instr_valid=1 two cycles after that (third cycle after E).
  - Accept at edge A → the next instr_valid rises in the third cycle after A.
  - Minimum 3 cycles per issued instruction.
- PC wrap-around: pc=2^ADDR_W-1 accepted → pc<=0 and fetching continues. No halt on wrap.
- instr_ready outside ISSUE is ignored.
- instr value 0 is a legal opcode and is issued normally. Only HALT_OP is suppressed.

Test Plan:
- Reset: drive reset=0 at arbitrary time, including during ISSUE with instr_valid=1 → all outputs 0 within the same cycle (asynchronous); state IDLE after release; start required to resume.
- Basic sequence: memory {0:4'h1, 1:4'h2, 2:4'h3, 3:4'hF}, instr_ready tied 1, start pulse → instr 1, 2, 3 each valid exactly one cycle, 3 cycles apart; then halted=1, pc=3, issue_count=3; 4'hF never seen with instr_valid=1.
- Backpressure: memory {0:4'h5, 1:4'hF}, instr_ready=0 for 10 cycles after instr_valid rises → instr=5 and pc=0 stable all 10 cycles, imem_rd=0; instr_ready=1 → single accept, pc=1, then halted=1.
- Immediate halt: memory {0:4'hF}, start → halted=1 in the third cycle after start; instr_valid never 1; issue_count=0.
- Wrap: ADDR_W=2, memory all 4'h7, instr_ready=1 → imem_addr sequence 0,1,2,3,0,1; issue_count increments by 1 per accept.
- Restart and ignored start: start asserted during ISSUE has no effect. After HALTED, start → pc=0, issue_count=0, halted=0, and the program replays identically.
